// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer: controller state encoding and
// default widths used by the sequencer and the hazard detector.
package pipeline_pkg;

    localparam int NB_ADDR  = 5;
    localparam int NB_DRAIN = 3;
    localparam int NB_CNT   = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // The pipeline registers advance only in these states.
    function automatic logic state_enables(input state_t st);
        return (st == ST_RUN) || (st == ST_STEP) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction in ID. Register 0 never creates a dependency.
module hazard_detect #(
    parameter int NB_ADDR = pipeline_pkg::NB_ADDR
) (
    input  logic               i_ex_mem_read,
    input  logic [NB_ADDR-1:0] i_ex_rt,
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    output logic               o_load_use
);

    logic rt_nonzero;
    logic rt_matches;

    assign rt_nonzero = (i_ex_rt != '0);
    assign rt_matches = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
    assign o_load_use = i_ex_mem_read && rt_nonzero && rt_matches;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller for the 5-stage pipeline: owns the global register
// enable, per-stage stall/flush controls, the HALT drain timer and cycle count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | pipeline frozen, waiting for a run or step command
// ST_RUN    | free running until HALT reaches ID
// ST_STEP   | exactly one enabled cycle, then back to idle
// ST_DRAIN  | fetch frozen, older instructions retire through WB
// ST_HALTED | program finished, frozen until reset
module pipeline_sequencer #(
    parameter int NB_ADDR  = pipeline_pkg::NB_ADDR,
    parameter int NB_DRAIN = pipeline_pkg::NB_DRAIN,
    parameter int NB_CNT   = pipeline_pkg::NB_CNT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_step,
    input  logic               i_halt_id,
    input  logic               i_ex_mem_read,
    input  logic [NB_ADDR-1:0] i_ex_rt,
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    input  logic               i_id_branch_taken,
    output logic               o_dunit_clk_en,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_if_id_flush,
    output logic               o_id_ex_flush,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_cycle_count
);

    import pipeline_pkg::*;

    localparam int NB_DCNT = (NB_DRAIN < 1) ? 1 : $clog2(NB_DRAIN + 1);
    localparam logic [NB_DCNT-1:0] DRAIN_LOAD = NB_DCNT'(NB_DRAIN);

    state_t              state_q, state_d;
    logic [NB_DCNT-1:0]  drain_cnt_q, drain_cnt_d;
    logic [NB_CNT-1:0]   cycle_cnt_q, cycle_cnt_d;

    logic en;
    logic load_use;
    logic draining;

    hazard_detect #(
        .NB_ADDR (NB_ADDR)
    ) u_hazard_detect (
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rt       (i_ex_rt),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .o_load_use    (load_use)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_halt_id) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_STEP: begin
                if (i_halt_id) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // <= 1 rather than == 1 so a zero-length drain cannot wrap.
                if (drain_cnt_q <= NB_DCNT'(1)) begin
                    state_d     = ST_HALTED;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - NB_DCNT'(1);
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (en && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + NB_CNT'(1);
        end
    end

    assign en       = state_enables(state_q);
    assign draining = (state_q == ST_DRAIN);

    // A stall holds IF_ID, so the branch flush waits for the re-resolve.
    assign o_dunit_clk_en = en;
    assign o_pc_write     = en && !load_use && !draining && !i_halt_id;
    assign o_if_id_write  = en && !load_use;
    assign o_id_ex_flush  = en && load_use;
    assign o_if_id_flush  = en && !load_use && (i_id_branch_taken || draining || i_halt_id);
    assign o_halted       = (state_q == ST_HALTED);
    assign o_cycle_count  = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized bench for pipeline_sequencer against a cycle-level behavioural
// model of the run/step/drain controller and its hazard controls.
module tb_pipeline_sequencer;

    localparam int NB_ADDR  = 5;
    localparam int NB_DRAIN = 3;
    localparam int NB_CNT   = 32;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_DRAIN  = 3;
    localparam int M_HALTED = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               run, step, halt;
    logic               mr;
    logic [NB_ADDR-1:0] ex_rt, id_rs, id_rt;
    logic               br;
    logic               clk_en, pc_write, if_id_write, if_id_flush, id_ex_flush, halted;
    logic [NB_CNT-1:0]  cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    int          m_mode  = M_IDLE;
    int          m_left  = 0;
    logic [31:0] m_count = '0;
    bit          m_known = 1'b0;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .NB_ADDR  (NB_ADDR),
        .NB_DRAIN (NB_DRAIN),
        .NB_CNT   (NB_CNT)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_run             (run),
        .i_step            (step),
        .i_halt_id         (halt),
        .i_ex_mem_read     (mr),
        .i_ex_rt           (ex_rt),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_branch_taken (br),
        .o_dunit_clk_en    (clk_en),
        .o_pc_write        (pc_write),
        .o_if_id_write     (if_id_write),
        .o_if_id_flush     (if_id_flush),
        .o_id_ex_flush     (id_ex_flush),
        .o_halted          (halted),
        .o_cycle_count     (cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_haz();
        mr = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0; br = 1'b0;
    endtask

    // Small register range so matches (and rt==0) happen often.
    task automatic rand_haz();
        mr    = 1'($urandom_range(0, 1));
        ex_rt = NB_ADDR'($urandom_range(0, 3));
        id_rs = NB_ADDR'($urandom_range(0, 3));
        id_rt = NB_ADDR'($urandom_range(0, 3));
        br    = ($urandom_range(0, 3) == 0);
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are checked
    // mid-cycle, then the model advances on the next rising edge.
    task automatic tick();
        bit en_m, lu_m;
        #3;
        en_m = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
        lu_m = mr && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        if (m_known) begin
            chk("clk_en",      32'(clk_en),      32'(en_m));
            chk("pc_write",    32'(pc_write),    32'(en_m && !lu_m && m_mode != M_DRAIN && !halt));
            chk("if_id_write", 32'(if_id_write), 32'(en_m && !lu_m));
            chk("id_ex_flush", 32'(id_ex_flush), 32'(en_m && lu_m));
            chk("if_id_flush", 32'(if_id_flush),
                32'(en_m && !lu_m && (br || m_mode == M_DRAIN || halt)));
            chk("halted",      32'(halted),      32'(m_mode == M_HALTED));
            chk("cycle_count", cycle_count,      m_count);
        end
        @(posedge clk);
        if (rst) begin
            m_mode  = M_IDLE;
            m_left  = 0;
            m_count = '0;
            m_known = 1'b1;
        end else begin
            if (en_m && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            case (m_mode)
                M_IDLE:  if (run) m_mode = M_RUN; else if (step) m_mode = M_STEP;
                M_RUN:   if (halt) begin m_mode = M_DRAIN; m_left = NB_DRAIN; end
                M_STEP:  if (halt) begin m_mode = M_DRAIN; m_left = NB_DRAIN; end
                         else m_mode = M_IDLE;
                M_DRAIN: begin
                    m_left = m_left - 1;
                    if (m_left <= 0) m_mode = M_HALTED;
                end
                default: m_mode = m_mode;
            endcase
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0;
        clr_haz();
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: nothing moves whatever the hazard inputs do.
        repeat (5) begin rand_haz(); tick(); end
        chk("idle_count", cycle_count, 32'd0);

        // Three spaced step pulses give exactly three enabled cycles.
        repeat (3) begin
            rand_haz();
            step = 1'b1; tick(); step = 1'b0;
            repeat (3) begin rand_haz(); tick(); end
        end
        chk("step_count", cycle_count, 32'd3);
        chk("step_idle",  32'(clk_en), 32'd0);

        // Free run with directed hazard cases.
        clr_haz();
        run = 1'b1; tick(); run = 1'b0;
        mr = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
        #2;
        chk("lu_pc_write",  32'(pc_write),    32'd0);
        chk("lu_ifid_wr",   32'(if_id_write), 32'd0);
        chk("lu_idex_fl",   32'(id_ex_flush), 32'd1);
        tick();
        ex_rt = 5'd0; id_rs = 5'd0;
        #2;
        chk("r0_pc_write",  32'(pc_write),    32'd1);
        chk("r0_idex_fl",   32'(id_ex_flush), 32'd0);
        tick();
        ex_rt = 5'd7; id_rt = 5'd7; br = 1'b1;
        #2;
        chk("lubr_ifid_fl", 32'(if_id_flush), 32'd0);
        chk("lubr_idex_fl", 32'(id_ex_flush), 32'd1);
        tick();
        mr = 1'b0;
        #2;
        chk("br_ifid_fl",   32'(if_id_flush), 32'd1);
        tick();

        // Random hazards while running; commands are ignored in RUN.
        repeat (200) begin
            rand_haz();
            run  = ($urandom_range(0, 7) == 0);
            step = ($urandom_range(0, 7) == 0);
            tick();
        end
        run = 1'b0; step = 1'b0;

        // HALT decoded mid-run, then drain and stick in HALTED.
        repeat (10) begin rand_haz(); tick(); end
        rand_haz();
        halt = 1'b1; tick(); halt = 1'b0;
        repeat (8) begin
            rand_haz();
            run  = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            tick();
        end
        run = 1'b0; step = 1'b0;
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_en",     32'(clk_en), 32'd0);

        // Reset in the middle of a drain, then restart.
        do_reset();
        run = 1'b1; tick(); run = 1'b0;
        repeat (5) begin rand_haz(); tick(); end
        halt = 1'b1; tick(); halt = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_en",    32'(clk_en), 32'd0);
        run = 1'b1; tick(); run = 1'b0;
        tick();
        chk("restart_en", 32'(clk_en), 32'd1);

        // HALT arriving during a single step still drains fully.
        do_reset();
        clr_haz();
        step = 1'b1; tick(); step = 1'b0;
        halt = 1'b1; tick(); halt = 1'b0;
        repeat (6) begin rand_haz(); tick(); end
        chk("step_halt", 32'(halted), 32'd1);

        // Random soak with sparse commands, halts and resets.
        do_reset();
        repeat (2000) begin
            rand_haz();
            run  = ($urandom_range(0, 49) == 0);
            step = ($urandom_range(0, 9) == 0);
            halt = ($urandom_range(0, 39) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
